// File: rtl/multi_channel_burst_divider.sv
// Purpose : multi-channel burst clock generator. Each burst is PULSES pulses
//           (HIGH cycles high, LOW cycles low), optionally followed by a gap.
//           Bursts rotate round-robin over the set bits of the channel mask.
// Latency : 1 cycle from enable sampled high to the first SAMPLE_CLK high
//           cycle. All outputs are registered.
// Backpressure: none. The block free-runs while enable is high. Dropping
//           enable returns it to IDLE at the next edge.
// Ports   : HF_CLK/NRST_sync clock and async active-low reset.
//           ENSAMP_sync|TEMP_RUN is the enable. HIGH/LOW/PULSES/GAP/CHMASK/
//           ONESHOT_sync are configuration inputs, latched at each burst start.
//           SAMPLE_CLK is one-hot or zero. phase is high during the gap.
//           CH_IDX is the active channel. BURST_DONE is a one-cycle
//           end-of-burst pulse. BUSY is high while in HIGH, LOW or GAP.
module multi_channel_burst_divider #(
  parameter int DIV_W   = 12,
  parameter int BURST_W = 4,
  parameter int GAP_W   = 10,
  parameter int NCH     = 4,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               HF_CLK,
  input  logic               NRST_sync,
  input  logic               ENSAMP_sync,
  input  logic               TEMP_RUN,
  input  logic [DIV_W-1:0]   HIGH_sync,
  input  logic [DIV_W-1:0]   LOW_sync,
  input  logic [BURST_W-1:0] PULSES_sync,
  input  logic [GAP_W-1:0]   GAP_sync,
  input  logic [NCH-1:0]     CHMASK_sync,
  input  logic               ONESHOT_sync,
  output logic [NCH-1:0]     SAMPLE_CLK,
  output logic               phase,
  output logic [CH_W-1:0]    CH_IDX,
  output logic               BURST_DONE,
  output logic               BUSY
);

  localparam int CNT_W = (DIV_W > GAP_W) ? DIV_W : GAP_W;

  typedef enum logic [2:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_GAP, ST_HOLD} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;                 // cycles left in current state, minus one
  logic [BURST_W-1:0] pulses_left, pulses_left_nxt; // pulses left after the current one
  logic [CH_W-1:0]    ch_nxt;
  logic               do_latch, restart, done_nxt;
  logic [NCH-1:0]     sample_nxt;
  logic               phase_nxt, busy_nxt;

  // Shadow configuration for the running burst. The pulse count and the mask
  // are consumed at latch time, into pulses_left and the channel pick.
  logic [DIV_W-1:0]   sh_high, sh_low;
  logic [GAP_W-1:0]   sh_gap;
  logic               sh_oneshot;

  logic enable;
  assign enable = ENSAMP_sync | TEMP_RUN;

  // Length-minus-one of a count in which zero means one.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [BURST_W-1:0] pulses_m1(input logic [BURST_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [CH_W-1:0] lowest_set(input logic [NCH-1:0] m);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (((m >> i) & NCH'(1)) != '0) lowest_set = CH_W'(i);
  endfunction

  // First set bit strictly after cur, wrapping. Offset NCH lands back on cur,
  // so a single-bit mask reselects the same channel.
  function automatic logic [CH_W-1:0] next_set(input logic [NCH-1:0] m,
                                               input logic [CH_W-1:0] cur);
    int idx;
    next_set = cur;
    for (int off = NCH; off >= 1; off--) begin
      idx = (int'(cur) + off) % NCH;
      if (((m >> idx) & NCH'(1)) != '0) next_set = CH_W'(idx);
    end
  endfunction

  // State register, counters, shadows and registered outputs.
  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pulses_left <= '0;
      sh_high     <= '0;
      sh_low      <= '0;
      sh_gap      <= '0;
      sh_oneshot  <= 1'b0;
      CH_IDX      <= '0;
      SAMPLE_CLK  <= '0;
      phase       <= 1'b0;
      BURST_DONE  <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pulses_left <= pulses_left_nxt;
      CH_IDX      <= ch_nxt;
      SAMPLE_CLK  <= sample_nxt;
      phase       <= phase_nxt;
      BURST_DONE  <= done_nxt;
      BUSY        <= busy_nxt;
      if (do_latch) begin
        sh_high    <= HIGH_sync;
        sh_low     <= LOW_sync;
        sh_gap     <= GAP_sync;
        sh_oneshot <= ONESHOT_sync;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    pulses_left_nxt = pulses_left;
    ch_nxt          = CH_IDX;
    do_latch        = 1'b0;
    restart         = 1'b0;
    done_nxt        = 1'b0;
    if (!enable) begin
      state_nxt       = ST_IDLE;
      cnt_nxt         = '0;
      pulses_left_nxt = '0;
      ch_nxt          = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CHMASK_sync != '0) begin
            do_latch        = 1'b1;
            state_nxt       = ST_HIGH;
            cnt_nxt         = len_m1(CNT_W'(HIGH_sync));
            pulses_left_nxt = pulses_m1(PULSES_sync);
            ch_nxt          = lowest_set(CHMASK_sync);
          end
        end
        ST_HIGH: begin
          if (cnt == '0) begin
            state_nxt = ST_LOW;
            cnt_nxt   = len_m1(CNT_W'(sh_low));
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ST_LOW: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else if (pulses_left != '0) begin
            pulses_left_nxt = pulses_left - 1'b1;
            state_nxt       = ST_HIGH;
            cnt_nxt         = len_m1(CNT_W'(sh_high));
          end else begin
            done_nxt = 1'b1;
            if (sh_oneshot) begin
              state_nxt = ST_HOLD;
              cnt_nxt   = '0;
              ch_nxt    = '0;
            end else if (sh_gap != '0) begin
              state_nxt = ST_GAP;
              cnt_nxt   = len_m1(CNT_W'(sh_gap));
            end else begin
              restart = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (cnt != '0) cnt_nxt = cnt - 1'b1;
          else           restart = 1'b1;
        end
        ST_HOLD: ;
        default: state_nxt = ST_IDLE;
      endcase

      // Back-to-back burst: re-latch config and step to the next channel of the new mask.
      if (restart) begin
        do_latch = 1'b1;
        if (CHMASK_sync == '0) begin
          state_nxt       = ST_IDLE;
          cnt_nxt         = '0;
          pulses_left_nxt = '0;
          ch_nxt          = '0;
        end else begin
          state_nxt       = ST_HIGH;
          cnt_nxt         = len_m1(CNT_W'(HIGH_sync));
          pulses_left_nxt = pulses_m1(PULSES_sync);
          ch_nxt          = next_set(CHMASK_sync, CH_IDX);
        end
      end
    end
  end

  // Output logic: computed from the next state so that the registered outputs line up with the state.
  always_comb begin
    sample_nxt = '0;
    if (state_nxt == ST_HIGH) sample_nxt[ch_nxt] = 1'b1;
    phase_nxt = (state_nxt == ST_GAP);
    busy_nxt  = (state_nxt == ST_HIGH) || (state_nxt == ST_LOW) || (state_nxt == ST_GAP);
  end

endmodule
